stage_4_mem: RTL
================

Name: stage_4_mem

Overview:
- MEM stage of the 5-stage in-order pipeline. Sits between stage_3_EX and stage_5_WB.
- Latches the EX→MEM bus and takes the synchronous data-SRAM read word, which returns in this stage.
- Performs load byte/half selection with sign or zero extension and builds the 70-bit MEM→WB bus.
- Drives a forwarding bus back to ID and takes part in the valid/allow pipeline handshake.

Parameters:
- BUS_3_4_W, 74, width of the EX→MEM bus.
- BUS_4_5_W, 70, width of the MEM→WB bus.
- FWD_W, 38, width of the forwarding bus to ID.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid_3  in  1  EX holds a valid instruction.
- allow_4  out  1  MEM can accept a new instruction this cycle.
- valid_4  out  1  MEM holds a valid instruction.
- allow_5  in  1  WB can accept.
- stage_3_to_4  in  74  {load_op[2:0], res_from_mem, rf_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
- data_sram_rdata  in  32  read word for the address issued by EX in the previous cycle.
- stage_4_to_5  out  70  {rf_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
- mem_fwd  out  38  {fwd_we, dest[4:0], final_result[31:0]}.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - valid_4 = 0.
  - Internal bus register = 0, so stage_4_to_5 = 0.
  - mem_fwd.fwd_we = 0.
- Handshake:
  - readygo_4 = 1 (constant).
  - allow_4 = !valid_4 | (readygo_4 & allow_5).
  - Each cycle with allow_4 = 1: valid_4 <= valid_3. Otherwise valid_4 holds.
- Bus latch:
  - When valid_3 & allow_4: bus register <= stage_3_to_4.
  - Otherwise the bus register holds, including while stalled.
  - Latency is 1 cycle from EX to the MEM outputs.
- Load data selection (combinational, from the latched alu_result[1:0] and data_sram_rdata):
  - Byte select: offset 0 → rdata[7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24].
  - Half select: offset[1]=0 → rdata[15:0], offset[1]=1 → [31:16]. offset[0] is ignored; misalignment is handled by a later exception block and is not flagged here.
  - load_op encoding:
    - 000 ld.w: whole word, address bits ignored.
    - 001 ld.b: sign-extend selected byte.
    - 010 ld.h: sign-extend selected half.
    - 011 ld.bu: zero-extend selected byte.
    - 100 ld.hu: zero-extend selected half.
    - 101–111: treated as ld.w.
- final_result = res_from_mem ? load_data : alu_result.
- stage_4_to_5 = {rf_we, dest, final_result, pc}. It is driven unqualified; WB gates with valid.
- mem_fwd:
  - fwd_we = valid_4 & rf_we & (dest != 0).
  - dest and final_result as above.
  - ID must ignore mem_fwd when fwd_we = 0.
- Boundary conditions:
  - Stall (valid_4 & !allow_5): bus register and valid_4 hold. data_sram_rdata is not re-captured, because the current WB always asserts allow_5. Any future stalling WB requires a holding register (out of scope).
  - Bubble in (allow_4 & !valid_3): valid_4 <= 0 and the bus register keeps stale contents. fwd_we = 0.
  - Simultaneous valid_3 and allow_5 with valid_4 = 1: new instruction replaces old in the same edge; no bubble.
  - Reset mid-operation: valid_4 is cleared on the next edge regardless of valid_3. The in-flight instruction is dropped.

Decomposition:
- Shared package (mycpu_defs):
  - Bus widths BUS_3_4_W, BUS_4_5_W, FWD_W.
  - LD_W/LD_B/LD_H/LD_BU/LD_HU load_op encodings.
  - Bus field offsets, shared with stage_3_EX and stage_5_WB.
- One sub-module: mem_load_align. It is purely combinational: (rdata, addr_lo[1:0], load_op) → load_data[31:0]. Instantiate it once.

Test Plan:
- Reset held 3 cycles with valid_3 = 1 → valid_4 = 0, stage_4_to_5 = 0, fwd_we = 0. First edge after release with valid_3 = 1 → valid_4 = 1.
- ALU op: bus pc=0x1C000010, alu_result=0x12345678, rf_we=1, dest=5, res_from_mem=0 → next cycle stage_4_to_5 = {1, 5, 0x12345678, 0x1C000010}; mem_fwd = {1, 5, 0x12345678}.
- Byte loads with rdata=0x80F07F01:
  - ld.b: offsets 0/1/2/3 → 0x00000001 / 0x0000007F / 0xFFFFFFF0 / 0xFFFFFF80.
  - ld.bu at offset 3 → 0x00000080.
- Half/word loads with rdata=0x8001F00F:
  - ld.h at offset 2 → 0xFFFF8001.
  - ld.hu at offset 0 → 0x0000F00F.
  - ld.w at offset 1 → 0x8001F00F.
- Forwarding gating: rf_we=1, dest=0 → fwd_we = 0. Valid instruction followed by a bubble → fwd_we drops to 0 the cycle after.
- Back-pressure with allow_5 forced 0 for 2 cycles while valid_4 = 1 and valid_3 = 1 → allow_4 = 0, bus and valid_4 held. On allow_5 = 1 the next instruction latches in that same edge.

Source files
------------

// File: rtl/stage_4_mem_pkg.sv
// Shared CPU definitions: pipeline bus widths, load opcodes and bus field offsets
// used by the EX, MEM and WB stages.
package mycpu_defs;

    localparam int BUS_3_4_W = 74;
    localparam int BUS_4_5_W = 70;
    localparam int FWD_W     = 38;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    // EX->MEM: {load_op[2:0], res_from_mem, rf_we, dest[4:0], alu_result[31:0], pc[31:0]}
    localparam int B34_PC_LSB      = 0;
    localparam int B34_ALU_LSB     = 32;
    localparam int B34_DEST_LSB    = 64;
    localparam int B34_RF_WE       = 69;
    localparam int B34_RES_MEM     = 70;
    localparam int B34_LOAD_OP_LSB = 71;

    // MEM->WB: {rf_we, dest[4:0], final_result[31:0], pc[31:0]}
    localparam int B45_PC_LSB   = 0;
    localparam int B45_RES_LSB  = 32;
    localparam int B45_DEST_LSB = 64;
    localparam int B45_RF_WE    = 69;

    // MEM->ID forwarding: {fwd_we, dest[4:0], final_result[31:0]}
    localparam int FWD_RES_LSB  = 0;
    localparam int FWD_DEST_LSB = 32;
    localparam int FWD_WE       = 37;

endpackage

// File: rtl/stage_4_mem_if.sv
// Handshake and data buses around the MEM stage. The slave modport is the MEM
// stage's view; master is the surrounding pipeline (EX, data SRAM, WB, ID).
interface stage_4_mem_if;
    import mycpu_defs::*;

    logic                 valid_3;
    logic                 allow_4;
    logic                 valid_4;
    logic                 allow_5;
    logic [BUS_3_4_W-1:0] stage_3_to_4;
    logic [31:0]          data_sram_rdata;
    logic [BUS_4_5_W-1:0] stage_4_to_5;
    logic [FWD_W-1:0]     mem_fwd;

    modport master (
        output valid_3, allow_5, stage_3_to_4, data_sram_rdata,
        input  allow_4, valid_4, stage_4_to_5, mem_fwd
    );

    modport slave (
        input  valid_3, allow_5, stage_3_to_4, data_sram_rdata,
        output allow_4, valid_4, stage_4_to_5, mem_fwd
    );

endinterface

// File: rtl/stage_4_mem_load_align.sv
// Load data alignment: picks the addressed byte/half out of the SRAM word and
// sign- or zero-extends it according to load_op.
module mem_load_align
    import mycpu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_op,
    output logic [31:0] load_data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        logic signed [31:0] w;
        w = v;
        return w;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        logic signed [31:0] w;
        w = v;
        return w;
    endfunction

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // addr_lo[0] is deliberately ignored; misaligned halves are trapped later.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (load_op)
            LD_B:    load_data = sext8(byte_sel);
            LD_H:    load_data = sext16(half_sel);
            LD_BU:   load_data = {24'd0, byte_sel};
            LD_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_4_mem.sv
// MEM stage: latches the EX bus, merges the returning SRAM read word and builds
// the WB bus plus the forwarding bus back to ID.
module stage_4_mem
    import mycpu_defs::*;
(
    input  logic         clk,
    input  logic         reset,
    stage_4_mem_if.slave pipe
);

    localparam logic READYGO_4 = 1'b1;

    logic                 vld_p0;
    logic [BUS_3_4_W-1:0] bus_p0;
    logic                 allow_4;

    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign allow_4 = !vld_p0 | (READYGO_4 & pipe.allow_5);

    // ---- EX -> MEM boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else if (allow_4) begin
            vld_p0 <= pipe.valid_3;
        end
    end

    // Stale contents are kept on bubbles; WB and ID qualify with valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_p0 <= '0;
        end else if (pipe.valid_3 && allow_4) begin
            bus_p0 <= pipe.stage_3_to_4;
        end
    end

    assign load_op      = bus_p0[B34_LOAD_OP_LSB +: 3];
    assign res_from_mem = bus_p0[B34_RES_MEM];
    assign rf_we        = bus_p0[B34_RF_WE];
    assign dest         = bus_p0[B34_DEST_LSB +: 5];
    assign alu_result   = bus_p0[B34_ALU_LSB +: 32];
    assign pc           = bus_p0[B34_PC_LSB +: 32];

    mem_load_align u_load_align (
        .rdata     (pipe.data_sram_rdata),
        .addr_lo   (alu_result[1:0]),
        .load_op   (load_op),
        .load_data (load_data)
    );

    assign final_result = res_from_mem ? load_data : alu_result;

    always_comb begin
        pipe.stage_4_to_5                       = '0;
        pipe.stage_4_to_5[B45_PC_LSB +: 32]     = pc;
        pipe.stage_4_to_5[B45_RES_LSB +: 32]    = final_result;
        pipe.stage_4_to_5[B45_DEST_LSB +: 5]    = dest;
        pipe.stage_4_to_5[B45_RF_WE]            = rf_we;
    end

    always_comb begin
        pipe.mem_fwd                        = '0;
        pipe.mem_fwd[FWD_RES_LSB +: 32]     = final_result;
        pipe.mem_fwd[FWD_DEST_LSB +: 5]     = dest;
        pipe.mem_fwd[FWD_WE]                = vld_p0 & rf_we & (dest != 5'd0);
    end

    assign pipe.allow_4 = allow_4;
    assign pipe.valid_4 = vld_p0;

endmodule
